// File: rtl/cache_fill_ctrl_if.sv
// Bundle of the miss-request, main-memory and cache-fill signals shared
// by the fill controller (master) and the surrounding caches/memory (slave).
interface cache_fill_ctrl_if;
    logic        i_miss;
    logic [15:0] i_addr;
    logic        d_miss;
    logic [15:0] d_addr;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic        mem_valid;
    logic [15:0] mem_data;
    logic [15:0] fill_addr;
    logic [15:0] fill_data;
    logic        i_write_data;
    logic        d_write_data;
    logic        i_write_meta;
    logic        d_write_meta;
    logic        i_busy;
    logic        d_busy;

    modport master (
        input  i_miss, i_addr, d_miss, d_addr, mem_valid, mem_data,
        output mem_read, mem_addr, fill_addr, fill_data,
               i_write_data, d_write_data, i_write_meta, d_write_meta,
               i_busy, d_busy
    );

    modport slave (
        output i_miss, i_addr, d_miss, d_addr, mem_valid, mem_data,
        input  mem_read, mem_addr, fill_addr, fill_data,
               i_write_data, d_write_data, i_write_meta, d_write_meta,
               i_busy, d_busy
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache miss fill controller: arbitrates I/D misses round-robin, streams
// the eight words of a 16 B block from pipelined main memory into the
// owning cache, then writes that cache's metadata to complete the fill.
module cache_fill_ctrl #(
    parameter int MEM_LATENCY     = 4,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic clk,
    input  logic rst,
    cache_fill_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        DRAIN = 2'd0,
        IDLE  = 2'd1,
        FILL  = 2'd2,
        META  = 2'd3
    } state_t;

    localparam int DRAIN_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MEM_LATENCY - 1);
    localparam logic [3:0] RECV_LAST = 4'(WORDS_PER_BLOCK - 1);

    // Owner / last-grant encoding: 0 = I-cache, 1 = D-cache
    localparam logic OWN_I = 1'b0;

    state_t              state_q;
    logic [DRAIN_W-1:0]  drain_cnt_q;
    logic [11:0]         base_q;
    logic                owner_q;
    logic                last_grant_q;
    logic [2:0]          issue_cnt_q;
    logic [3:0]          recv_cnt_q;
    logic                mem_read_q;
    logic [15:0]         mem_addr_q;
    logic                i_busy_q;
    logic                d_busy_q;
    logic                i_meta_q;
    logic                d_meta_q;

    logic                grant_valid_d;
    logic                grant_to_d_d;
    logic [11:0]         grant_base_d;
    logic                accept_d;
    logic [15:0]         fill_addr_d;

    // Word offset bits of the miss addresses select nothing: fills are whole blocks
    logic unused_addr_lo;
    assign unused_addr_lo = ^{bus.i_addr[3:0], bus.d_addr[3:0]};

    // Arbitration: single requester wins outright, a tie goes to the one not granted last
    always_comb begin
        grant_valid_d = bus.i_miss | bus.d_miss;
        grant_to_d_d  = 1'b0;
        if (bus.d_miss && !bus.i_miss) begin
            grant_to_d_d = 1'b1;
        end else if (bus.d_miss && bus.i_miss) begin
            grant_to_d_d = (last_grant_q == OWN_I);
        end
        grant_base_d = grant_to_d_d ? bus.d_addr[15:4] : bus.i_addr[15:4];
    end

    // A returned word is consumed only while filling and before the block is complete
    always_comb begin
        accept_d    = (state_q == FILL) && bus.mem_valid && (recv_cnt_q <= RECV_LAST);
        fill_addr_d = 16'h0000;
        if (accept_d) begin
            fill_addr_d = {base_q, recv_cnt_q[2:0], 1'b0};
        end else if (state_q == META) begin
            fill_addr_d = {base_q, 4'b0000};
        end
    end

    // Main FSM: drain stale returns after reset, arbitrate, issue/receive the block, write metadata
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= DRAIN;
            drain_cnt_q  <= '0;
            base_q       <= '0;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            mem_read_q   <= 1'b0;
            mem_addr_q   <= '0;
            i_busy_q     <= 1'b0;
            d_busy_q     <= 1'b0;
            i_meta_q     <= 1'b0;
            d_meta_q     <= 1'b0;
        end else begin
            case (state_q)
                DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        drain_cnt_q <= '0;
                        state_q     <= IDLE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end

                IDLE: begin
                    if (grant_valid_d) begin
                        state_q     <= FILL;
                        owner_q     <= grant_to_d_d;
                        base_q      <= grant_base_d;
                        i_busy_q    <= ~grant_to_d_d;
                        d_busy_q    <= grant_to_d_d;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= {grant_base_d, 4'b0000};
                        issue_cnt_q <= 3'd1;
                        recv_cnt_q  <= '0;
                    end
                end

                FILL: begin
                    // Issue side: word 0 went out with the grant, the wrap back to 0 means all eight are out
                    if (mem_read_q) begin
                        if (issue_cnt_q == 3'd0) begin
                            mem_read_q <= 1'b0;
                        end else begin
                            mem_addr_q  <= {base_q, issue_cnt_q, 1'b0};
                            issue_cnt_q <= issue_cnt_q + 3'd1;
                        end
                    end
                    // Receive side runs independently so memory bubbles are tolerated
                    if (accept_d) begin
                        recv_cnt_q <= recv_cnt_q + 4'd1;
                        if (recv_cnt_q == RECV_LAST) begin
                            state_q    <= META;
                            mem_read_q <= 1'b0;
                            i_meta_q   <= ~owner_q;
                            d_meta_q   <= owner_q;
                        end
                    end
                end

                META: begin
                    state_q      <= IDLE;
                    last_grant_q <= owner_q;
                    recv_cnt_q   <= '0;
                    i_meta_q     <= 1'b0;
                    d_meta_q     <= 1'b0;
                    i_busy_q     <= 1'b0;
                    d_busy_q     <= 1'b0;
                end

                default: begin
                    state_q <= DRAIN;
                end
            endcase
        end
    end

    assign bus.mem_read     = mem_read_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.fill_addr    = fill_addr_d;
    assign bus.fill_data    = bus.mem_data;
    assign bus.i_write_data = accept_d & (owner_q == OWN_I);
    assign bus.d_write_data = accept_d & (owner_q != OWN_I);
    assign bus.i_write_meta = i_meta_q;
    assign bus.d_write_meta = d_meta_q;
    assign bus.i_busy       = i_busy_q;
    assign bus.d_busy       = d_busy_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: a pipelined memory model plus a
// scoreboard of expected memory issues and cache write strobes.
module tb_cache_fill_ctrl;

    localparam int L = 4;

    typedef struct packed {
        logic [3:0]  strobes;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] addr;
        int          ready;
    } pend_t;

    logic clk = 1'b0;
    logic rst;

    cache_fill_ctrl_if bus ();

    cache_fill_ctrl #(
        .MEM_LATENCY    (L),
        .WORDS_PER_BLOCK(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          totalChecks = 0;
    int          badChecks   = 0;
    wr_t         expQ[$];
    logic [15:0] issueQ[$];
    pend_t       pendQ[$];
    int          edgeCnt     = 0;
    bit          bubbleEn    = 1'b0;
    bit          spurValid   = 1'b0;
    bit          monEn       = 1'b0;
    int          iMetaCount  = 0;

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Queue the expected issues, data writes and metadata write of one block fill
    task automatic pushFill(input bit toD, input logic [15:0] addr);
        logic [15:0] a;
        logic [2:0]  kk;
        wr_t         w;
        for (int k = 0; k < 8; k++) begin
            kk = 3'(k);
            a  = {addr[15:4], kk, 1'b0};
            issueQ.push_back(a);
            w.strobes = toD ? 4'b0100 : 4'b1000;
            w.addr    = a;
            w.data    = memWord(a);
            expQ.push_back(w);
        end
        w.strobes = toD ? 4'b0001 : 4'b0010;
        w.addr    = {addr[15:4], 4'b0000};
        w.data    = 16'h0000;
        expQ.push_back(w);
    endtask

    task automatic waitMeta(input bit toD, input string tag, output int cycles);
        bit found = 1'b0;
        cycles = 0;
        while (!found && cycles < 200) begin
            @(posedge clk);
            #2;
            cycles++;
            found = toD ? (bus.d_write_meta === 1'b1) : (bus.i_write_meta === 1'b1);
        end
        if (!found) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic waitDataWrites(input bit toD, input int n, input string tag);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < 200) begin
            @(posedge clk);
            #2;
            cyc++;
            if (toD ? (bus.d_write_data === 1'b1) : (bus.i_write_data === 1'b1)) seen++;
        end
        if (seen < n) checkOutput({tag, "_timeout"}, 64'(seen), 64'(n));
    endtask

    // Pipelined memory: captures issues at the edge, returns each word L cycles after its issue cycle
    always @(posedge clk) begin
        pend_t p;
        edgeCnt++;
        if (bus.mem_read === 1'b1) begin
            p.addr  = bus.mem_addr;
            p.ready = edgeCnt + L - 1;
            pendQ.push_back(p);
        end
        #1;
        if (pendQ.size() > 0 && pendQ[0].ready <= edgeCnt && !(bubbleEn && (edgeCnt % 3 == 0))) begin
            p = pendQ.pop_front();
            bus.mem_valid = 1'b1;
            bus.mem_data  = memWord(p.addr);
        end else if (spurValid) begin
            bus.mem_valid = 1'b1;
            bus.mem_data  = 16'h5EED;
        end else begin
            bus.mem_valid = 1'b0;
            bus.mem_data  = 16'hBEEF;
        end
    end

    // Scoreboard monitor: every strobe and every memory issue must match the head of its queue
    always @(negedge clk) begin
        logic [3:0] s;
        wr_t        e;
        if (monEn) begin
            s = {bus.i_write_data, bus.d_write_data, bus.i_write_meta, bus.d_write_meta};
            if (s[1] === 1'b1) iMetaCount++;
            if (s !== 4'b0000) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpStrobe", 64'(s), 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("fillWrite",
                                64'({s, bus.fill_addr, (e.strobes[1] | e.strobes[0]) ? 16'h0000 : bus.fill_data}),
                                64'(e));
                end
            end
            if (bus.mem_read !== 1'b0) begin
                if (issueQ.size() == 0) checkOutput("unexpIssue", 64'(bus.mem_read), 64'd0);
                else checkOutput("memAddr", 64'(bus.mem_addr), 64'(issueQ.pop_front()));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence
    initial begin
        int k;
        int rdCnt;
        int cyc;
        int metaBefore;
        logic [3:0] acc;

        rst = 1'b1;
        bus.i_miss = 1'b0;
        bus.d_miss = 1'b0;
        bus.i_addr = 16'h0000;
        bus.d_addr = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rstOutputs",
                    64'({bus.mem_read, bus.mem_addr, bus.fill_addr, bus.i_write_data, bus.d_write_data,
                         bus.i_write_meta, bus.d_write_meta, bus.i_busy, bus.d_busy}), 64'd0);
        checkOutput("rstFillData", 64'(bus.fill_data), 64'(bus.mem_data));
        rst   = 1'b0;
        monEn = 1'b1;
        repeat (L + 2) @(posedge clk);
        #2;

        // Tie from reset: D first, then I while D is still held, since D was granted last
        bus.i_addr = 16'h4A5C;
        bus.d_addr = 16'h77F8;
        pushFill(1'b1, bus.d_addr);
        pushFill(1'b0, bus.i_addr);
        bus.i_miss = 1'b1;
        bus.d_miss = 1'b1;
        @(posedge clk); #2;
        checkOutput("tie1Busy", 64'({bus.i_busy, bus.d_busy}), 64'(2'b01));
        waitMeta(1'b1, "tie1Meta", cyc);
        @(posedge clk); #2;
        @(posedge clk); #2;
        checkOutput("tie2Busy", 64'({bus.i_busy, bus.d_busy}), 64'(2'b10));
        bus.d_miss = 1'b0;
        waitMeta(1'b0, "tie2Meta", cyc);
        bus.i_miss = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        // Fresh tie after an I grant: D wins again
        bus.i_addr = 16'h0100;
        bus.d_addr = 16'hFFF0;
        pushFill(1'b1, bus.d_addr);
        pushFill(1'b0, bus.i_addr);
        bus.i_miss = 1'b1;
        bus.d_miss = 1'b1;
        @(posedge clk); #2;
        checkOutput("tie3Busy", 64'({bus.i_busy, bus.d_busy}), 64'(2'b01));
        waitMeta(1'b1, "tie3Meta", cyc);
        bus.d_miss = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        checkOutput("tie4Busy", 64'({bus.i_busy, bus.d_busy}), 64'(2'b10));
        waitMeta(1'b0, "tie4Meta", cyc);
        bus.i_miss = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("tieQueues", 64'(expQ.size() + issueQ.size()), 64'd0);

        // D miss only, timing of grant, issues and metadata write
        bus.d_addr = 16'h1234;
        pushFill(1'b1, bus.d_addr);
        bus.d_miss = 1'b1;
        k = 0;
        rdCnt = 0;
        while (bus.d_write_meta !== 1'b1 && k < 100) begin
            @(posedge clk); #2;
            k++;
            if (bus.mem_read === 1'b1) rdCnt++;
            if (k == 1) begin
                checkOutput("dOnlyGrant", 64'({bus.i_busy, bus.d_busy, bus.mem_read}), 64'(3'b011));
                bus.d_miss = 1'b0;
            end
            if (k == 10) checkOutput("dOnlyAddrHold", 64'({bus.mem_read, bus.mem_addr}), 64'({1'b0, 16'h123E}));
        end
        checkOutput("dOnlyMetaCycle", 64'(k), 64'd13);
        checkOutput("dOnlyReadCnt", 64'(rdCnt), 64'd8);
        checkOutput("dOnlyMetaAddr", 64'(bus.fill_addr), 64'(16'h1230));
        @(posedge clk); #2;
        checkOutput("dOnlyBusyEnd", 64'({bus.i_busy, bus.d_busy}), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("dOnlyQueues", 64'(expQ.size() + issueQ.size()), 64'd0);

        // Memory with bubbles
        bubbleEn = 1'b1;
        bus.i_addr = 16'hC0DE;
        pushFill(1'b0, bus.i_addr);
        bus.i_miss = 1'b1;
        @(posedge clk); #2;
        bus.i_miss = 1'b0;
        waitMeta(1'b0, "bubbleMeta", cyc);
        checkOutput("bubbleLate", 64'(cyc > 12), 64'd1);
        bubbleEn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("bubbleQueues", 64'(expQ.size() + issueQ.size()), 64'd0);

        // Spurious mem_valid in IDLE
        spurValid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        spurValid = 1'b0;
        @(posedge clk); #2;
        checkOutput("spurIdle", 64'({bus.i_busy, bus.d_busy, bus.mem_read}), 64'd0);

        // I miss dropped right after grant, with a spurious mem_valid during META
        bus.i_addr = 16'h2468;
        pushFill(1'b0, bus.i_addr);
        metaBefore = iMetaCount;
        bus.i_miss = 1'b1;
        @(posedge clk); #2;
        checkOutput("dropBusy", 64'({bus.i_busy, bus.d_busy}), 64'(2'b10));
        bus.i_miss = 1'b0;
        waitDataWrites(1'b0, 8, "dropWrites");
        spurValid = 1'b1;
        @(posedge clk); #2;
        checkOutput("dropMeta", 64'({bus.i_write_meta, bus.mem_valid}), 64'(2'b11));
        @(posedge clk); #2;
        spurValid = 1'b0;
        checkOutput("dropIdle", 64'({bus.i_busy, bus.d_busy, bus.mem_read}), 64'd0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("dropMetaOnce", 64'(iMetaCount - metaBefore), 64'd1);
        checkOutput("dropQueues", 64'(expQ.size() + issueQ.size()), 64'd0);

        // Reset at the 5th data write of an I fill
        bus.i_addr = 16'hABC0;
        pushFill(1'b0, bus.i_addr);
        bus.i_miss = 1'b1;
        @(posedge clk); #2;
        bus.i_miss = 1'b0;
        waitDataWrites(1'b0, 5, "rstWrites");
        rst = 1'b1;
        @(posedge clk); #2;
        expQ.delete();
        issueQ.delete();
        checkOutput("rstMidOutputs",
                    64'({bus.mem_read, bus.mem_addr, bus.fill_addr, bus.i_write_data, bus.d_write_data,
                         bus.i_write_meta, bus.d_write_meta, bus.i_busy, bus.d_busy}), 64'd0);
        rst = 1'b0;
        bus.d_addr = 16'h0F00;
        pushFill(1'b1, bus.d_addr);
        bus.d_miss = 1'b1;
        k = 0;
        acc = 4'b0000;
        while (bus.d_busy !== 1'b1 && k < 50) begin
            @(posedge clk); #2;
            k++;
            acc = acc | {bus.i_write_data, bus.d_write_data, bus.i_write_meta, bus.d_write_meta};
        end
        checkOutput("drainGrant", 64'(k), 64'd5);
        checkOutput("staleStrobes", 64'(acc), 64'd0);
        bus.d_miss = 1'b0;
        waitMeta(1'b1, "postRstMeta", cyc);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("finalQueues", 64'(expQ.size() + issueQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
